// File: rtl/chknorm_stream_pkg.sv
`default_nettype none
// ============================================================================
// chknorm_stream_pkg : field constants and FSM encoding for chknorm_stream
// Rev 1.0
// ============================================================================
package chknorm_stream_pkg;

  localparam logic [31:0] Q     = 32'd8380417;
  localparam logic [31:0] QINV  = 32'd58728449;
  localparam int          N     = 256;
  localparam logic [31:0] QHALF = (Q - 32'd1) >> 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/chknorm_stream_if.sv
`default_nettype none
// ============================================================================
// chknorm_stream_if : coefficient stream, control and result bundle
// Rev 1.0
// ============================================================================
interface chknorm_stream_if;

  logic        start_i;
  logic [31:0] bound_i;
  logic        in_valid_i;
  logic [31:0] in_data_i;
  logic        in_ready_o;
  logic        res_valid_o;
  logic        res_ready_i;
  logic        res_pass_o;
  logic [7:0]  res_first_idx_o;
  logic        res_range_err_o;
  logic        busy_o;

  modport slave (
    input  start_i, bound_i, in_valid_i, in_data_i, res_ready_i,
    output in_ready_o, res_valid_o, res_pass_o, res_first_idx_o,
           res_range_err_o, busy_o
  );

  modport master (
    output start_i, bound_i, in_valid_i, in_data_i, res_ready_i,
    input  in_ready_o, res_valid_o, res_pass_o, res_first_idx_o,
           res_range_err_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/chknorm_stream_centered_abs.sv
`default_nettype none
// ============================================================================
// chknorm_stream_centered_abs : canonical coefficient -> |centered value|
// Rev 1.0
// ============================================================================
module chknorm_stream_centered_abs
  import chknorm_stream_pkg::*;
(
  input  logic [31:0] a_i,
  output logic [31:0] mag_o,
  output logic        range_err_o
);

  logic [31:0] t;

  // Two's-complement wrap of a - Q yields the negative centered value.
  always_comb begin
    t           = (a_i > QHALF) ? (a_i - Q) : a_i;
    mag_o       = t[31] ? (32'd0 - t) : t;
    range_err_o = (a_i >= Q);
  end

endmodule
`default_nettype wire

// File: rtl/chknorm_stream.sv
`default_nettype none
// ============================================================================
// chknorm_stream : infinity-norm check of a 256-coefficient canonical stream
// Rev 1.0
// ============================================================================
module chknorm_stream
  import chknorm_stream_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  chknorm_stream_if.slave  bus
);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [31:0] bound_q;
  logic [31:0] a_q;
  logic [7:0]  idx_q;
  logic        v0_q;
  logic        fail_q;
  logic        err_q;
  logic [7:0]  fidx_q;

  logic        hs;
  logic        done;
  logic [31:0] mag;
  logic        range_err;
  logic        fail_c;

  assign hs   = (state_q == ST_RUN) && bus.in_valid_i;
  assign done = (state_q == ST_DONE);

  chknorm_stream_centered_abs u_centered_abs (
    .a_i         (a_q),
    .mag_o       (mag),
    .range_err_o (range_err)
  );

  assign fail_c = range_err || (mag >= bound_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start_i) state_d = ST_RUN;
      ST_RUN:   if (hs && (cnt_q == 8'(N - 1))) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  if (bus.res_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bound_q <= '0;
      a_q     <= '0;
      idx_q   <= '0;
      v0_q    <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= 1'b0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      v0_q    <= hs;
      if (hs) begin
        a_q   <= bus.in_data_i;
        idx_q <= cnt_q;
        cnt_q <= cnt_q + 8'd1;
      end
      if ((state_q == ST_IDLE) && bus.start_i) begin
        bound_q <= bus.bound_i;
        cnt_q   <= '0;
        fail_q  <= 1'b0;
        err_q   <= 1'b0;
        fidx_q  <= '0;
      end else if (v0_q) begin
        // Only the earliest failing index is kept.
        if (fail_c && !fail_q) fidx_q <= idx_q;
        fail_q <= fail_q | fail_c;
        err_q  <= err_q | range_err;
      end
    end
  end

  assign bus.in_ready_o      = (state_q == ST_RUN);
  assign bus.res_valid_o     = done;
  assign bus.res_pass_o      = done && !fail_q;
  assign bus.res_first_idx_o = done ? fidx_q : 8'd0;
  assign bus.res_range_err_o = done && err_q;
  assign bus.busy_o          = (state_q != ST_IDLE);

endmodule
`default_nettype wire
